// File: rtl/change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// change_dispenser_pkg
// Shared definitions for the change dispenser:
//   state_e       - controller state encoding
//   coin_code_e   - coin codes 0..5 as presented on O_COIN_SEL
//   NUM_COINS     - number of denominations
//   coin_value()  - coin-value table (code -> cents)
// -----------------------------------------------------------------------------
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_FINISH
    } state_e;

    localparam int NUM_COINS = 6;

    typedef enum logic [2:0] {
        COIN_1   = 3'd0,
        COIN_5   = 3'd1,
        COIN_10  = 3'd2,
        COIN_25  = 3'd3,
        COIN_100 = 3'd4,
        COIN_500 = 3'd5
    } coin_code_e;

    // Coin-value table in cents; codes 6 and 7 are unused and map to 0.
    function automatic logic [15:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_1:   return 16'd1;
            COIN_5:   return 16'd5;
            COIN_10:  return 16'd10;
            COIN_25:  return 16'd25;
            COIN_100: return 16'd100;
            COIN_500: return 16'd500;
            default:  return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Request / ejector bundle of the change dispenser.
//   slave  modport : the dispenser (takes I_*, drives O_*)
//   master modport : the controller / ejector side (drives I_*, takes O_*)
// Signals:
//   I_START, I_CHANGE[15:0]       dispense request and amount
//   I_COIN_ACK                    ejector confirms the presented coin
//   O_COIN_VALID, O_COIN_SEL[2:0] coin request to the ejector
//   O_REMAIN[15:0]                amount still to dispense
//   O_BUSY, O_DONE, O_FAULT       status
// Macro COIN_INVENTORY_EN adds I_REFILL, I_REFILL_SEL[2:0], I_REFILL_CNT[CNT_W-1:0].
// -----------------------------------------------------------------------------
interface change_dispenser_if #(
    parameter int CNT_W = 8
);
    logic        I_START;
    logic [15:0] I_CHANGE;
    logic        I_COIN_ACK;
    logic        O_COIN_VALID;
    logic [2:0]  O_COIN_SEL;
    logic [15:0] O_REMAIN;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_FAULT;

`ifdef COIN_INVENTORY_EN
    logic             I_REFILL;
    logic [2:0]       I_REFILL_SEL;
    logic [CNT_W-1:0] I_REFILL_CNT;

    modport slave (
        input  I_START, I_CHANGE, I_COIN_ACK, I_REFILL, I_REFILL_SEL, I_REFILL_CNT,
        output O_COIN_VALID, O_COIN_SEL, O_REMAIN, O_BUSY, O_DONE, O_FAULT
    );
    modport master (
        output I_START, I_CHANGE, I_COIN_ACK, I_REFILL, I_REFILL_SEL, I_REFILL_CNT,
        input  O_COIN_VALID, O_COIN_SEL, O_REMAIN, O_BUSY, O_DONE, O_FAULT
    );
`else
    modport slave (
        input  I_START, I_CHANGE, I_COIN_ACK,
        output O_COIN_VALID, O_COIN_SEL, O_REMAIN, O_BUSY, O_DONE, O_FAULT
    );
    modport master (
        output I_START, I_CHANGE, I_COIN_ACK,
        input  O_COIN_VALID, O_COIN_SEL, O_REMAIN, O_BUSY, O_DONE, O_FAULT
    );
`endif

endinterface

// File: rtl/change_dispenser_coin_select.sv
// -----------------------------------------------------------------------------
// change_dispenser_coin_select
// Combinational greedy picker: the largest available coin not exceeding remain.
//   remain[15:0]          amount still owed
//   avail[NUM_COINS-1:0]  per-code availability mask
//   found                 a usable coin exists
//   code[2:0]             its coin code
//   value[15:0]           its value in cents
// -----------------------------------------------------------------------------
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
(
    input  logic [15:0]          remain,
    input  logic [NUM_COINS-1:0] avail,
    output logic                 found,
    output logic [2:0]           code,
    output logic [15:0]          value
);

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that left
        // one unassigned would infer a latch.
        found = 1'b0;
        code  = 3'd0;
        value = 16'd0;
        // Codes ascend with value, so the last match is the largest coin.
        for (int i = 0; i < NUM_COINS; i++) begin
            if (avail[i] && (coin_value(3'(i)) <= remain)) begin
                found = 1'b1;
                code  = 3'(i);
                value = coin_value(3'(i));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Greedy coin-change controller driving a coin ejector with a valid/ack
// handshake and an acknowledge timeout.
// Parameters:
//   ACK_TIMEOUT  max cycles O_COIN_VALID waits for I_COIN_ACK before faulting
//   CNT_W        width of each per-denomination inventory counter
// Ports:
//   I_CLK        clock, rising edge
//   I_RESET_N    asynchronous active-low reset
//   bus          change_dispenser_if.slave (request, ejector handshake, status)
// Optional feature: define COIN_INVENTORY_EN to add per-coin inventory counts
// with refill inputs; coins whose count is zero are skipped. Without it every
// denomination is unlimited.
// -----------------------------------------------------------------------------
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              I_CLK,
    input  logic              I_RESET_N,
    change_dispenser_if.slave bus
);

    // Wait counter runs 0..ACK_TIMEOUT-1; reaching the last value without an
    // ack means the coin was presented for ACK_TIMEOUT cycles.
    localparam int                WAIT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    state_e               state, state_next;
    logic [15:0]          remain, remain_next;
    logic [2:0]           coin_sel, coin_sel_next;
    logic [15:0]          coin_val, coin_val_next;
    logic                 fault, fault_next;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;

    logic [NUM_COINS-1:0] avail;
    logic                 found;
    logic [2:0]           found_code;
    logic [15:0]          found_value;
    logic                 coin_taken;

    change_dispenser_coin_select coin_select (
        .remain (remain),
        .avail  (avail),
        .found  (found),
        .code   (found_code),
        .value  (found_value)
    );

    // The ejector only counts when a coin is actually presented.
    assign coin_taken = (state == S_EJECT) && bus.I_COIN_ACK;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state    <= S_IDLE;
            remain   <= 16'd0;
            coin_sel <= 3'd0;
            coin_val <= 16'd0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values that existed before this edge.
            state    <= state_next;
            remain   <= remain_next;
            coin_sel <= coin_sel_next;
            coin_val <= coin_val_next;
            fault    <= fault_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        remain_next   = remain;
        coin_sel_next = coin_sel;
        coin_val_next = coin_val;
        fault_next    = fault;
        wait_cnt_next = wait_cnt;

        case (state)
            S_IDLE: begin
                if (bus.I_START) begin
                    remain_next = bus.I_CHANGE;
                    fault_next  = 1'b0;
                    state_next  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remain == 16'd0) begin
                    state_next = S_FINISH;
                end else if (found) begin
                    coin_sel_next = found_code;
                    coin_val_next = found_value;
                    wait_cnt_next = '0;
                    state_next    = S_EJECT;
                end else begin
                    // Money still owed but nothing left to pay it with.
                    fault_next = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_EJECT: begin
                if (bus.I_COIN_ACK) begin
                    // Greedy selection guarantees coin_val <= remain.
                    remain_next = remain - coin_val;
                    state_next  = S_SELECT;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_next = 1'b1;
                    state_next = S_FINISH;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef COIN_INVENTORY_EN
    logic [CNT_W-1:0] coin_cnt [NUM_COINS];

    // NOTE: the count array is reset explicitly; an empty dispenser must not
    // offer coins it was never given.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                coin_cnt[i] <= '0;
            end
        end else if ((state == S_IDLE) && bus.I_REFILL) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (bus.I_REFILL_SEL == 3'(i)) begin
                    coin_cnt[i] <= bus.I_REFILL_CNT;
                end
            end
        end else if (coin_taken) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (coin_sel == 3'(i)) begin
                    coin_cnt[i] <= coin_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            avail[i] = (coin_cnt[i] != '0);
        end
    end
`else
    assign avail = '1;
`endif

    assign bus.O_COIN_VALID = (state == S_EJECT);
    assign bus.O_COIN_SEL   = coin_sel;
    assign bus.O_REMAIN     = remain;
    assign bus.O_BUSY       = (state != S_IDLE);
    assign bus.O_DONE       = (state == S_FINISH);
    assign bus.O_FAULT      = fault;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Directed bench for change_dispenser. Expected coin codes and completion
// results are queued when a transaction is issued; a monitor compares them
// whenever the dispenser presents a coin or pulses O_DONE. An ejector model
// acknowledges each coin after a programmable number of cycles (0 = never).
// Build with COIN_INVENTORY_EN to add the inventory scenario.
// -----------------------------------------------------------------------------
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    typedef struct packed {
        logic [15:0] remain;
        logic        fault;
    } done_t;

    logic I_CLK     = 1'b0;
    logic I_RESET_N = 1'b1;

    change_dispenser_if #(.CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .I_CLK     (I_CLK),
        .I_RESET_N (I_RESET_N),
        .bus       (bus)
    );

    always #5 I_CLK = ~I_CLK;

    logic [2:0] exp_codes [$];
    done_t      exp_done  [$];
    int         checks    = 0;
    int         errors    = 0;
    int         ack_delay = 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Ejector model: ack is sampled ack_delay edges after O_COIN_VALID rises.
    initial begin
        int waited;
        waited = 0;
        bus.I_COIN_ACK = 1'b0;
        forever begin
            @(negedge I_CLK);
            if (bus.O_COIN_VALID && !bus.I_COIN_ACK && ack_delay > 0) begin
                if (waited >= ack_delay - 1) begin
                    bus.I_COIN_ACK = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                bus.I_COIN_ACK = 1'b0;
                waited = 0;
            end
        end
    end

    // Monitor: compare each presented coin and each completion against the queues.
    initial begin
        logic       prev_valid;
        logic [2:0] held;
        done_t      d;
        prev_valid = 1'b0;
        held       = 3'd0;
        forever begin
            @(negedge I_CLK);
            if (!I_RESET_N) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.O_COIN_VALID) begin
                    if (!prev_valid) begin
                        if (exp_codes.size() == 0) begin
                            fail("unexpected_coin");
                        end else begin
                            held = exp_codes.pop_front();
                            check("coin_sel", bus.O_COIN_SEL, held);
                        end
                    end else begin
                        check("coin_sel_stable", bus.O_COIN_SEL, held);
                    end
                end
                if (bus.O_DONE) begin
                    if (exp_done.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_remain", bus.O_REMAIN, d.remain);
                        check("done_fault", bus.O_FAULT, d.fault);
                    end
                end
                prev_valid = bus.O_COIN_VALID;
            end
        end
    end

    // Drive a one-cycle I_START; returns at the first negedge after it was sampled.
    task automatic start_txn(input logic [15:0] change, input int delay);
        ack_delay = delay;
        @(negedge I_CLK);
        bus.I_START  = 1'b1;
        bus.I_CHANGE = change;
        @(negedge I_CLK);
        bus.I_START  = 1'b0;
        bus.I_CHANGE = 16'd0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge I_CLK);
            if (bus.O_DONE) seen = 1'b1;
        end
        if (!seen) fail({name, "_done_timeout"});
    endtask

    // Wait for done, then confirm it was a single-cycle pulse back to idle.
    task automatic finish_txn(input string name);
        wait_done(name, 100);
        @(negedge I_CLK);
        check({name, "_done_pulse"}, bus.O_DONE, 1'b0);
        check({name, "_idle"}, bus.O_BUSY, 1'b0);
    endtask

    task automatic wait_valid(input string name, input logic level, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge I_CLK);
            if (bus.O_COIN_VALID == level) seen = 1'b1;
        end
        if (!seen) fail({name, "_valid_timeout"});
    endtask

`ifdef COIN_INVENTORY_EN
    task automatic refill(input logic [2:0] sel, input logic [CNT_W-1:0] cnt);
        @(negedge I_CLK);
        bus.I_REFILL     = 1'b1;
        bus.I_REFILL_SEL = sel;
        bus.I_REFILL_CNT = cnt;
        @(negedge I_CLK);
        bus.I_REFILL     = 1'b0;
    endtask
`endif

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"},  bus.O_COIN_VALID, 1'b0);
        check({name, "_sel"},    bus.O_COIN_SEL,   3'd0);
        check({name, "_remain"}, bus.O_REMAIN,     16'd0);
        check({name, "_busy"},   bus.O_BUSY,       1'b0);
        check({name, "_done"},   bus.O_DONE,       1'b0);
        check({name, "_fault"},  bus.O_FAULT,      1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.I_START  = 1'b0;
        bus.I_CHANGE = 16'd0;
`ifdef COIN_INVENTORY_EN
        bus.I_REFILL     = 1'b0;
        bus.I_REFILL_SEL = 3'd0;
        bus.I_REFILL_CNT = '0;
`endif
        #2 I_RESET_N = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge I_CLK);
        I_RESET_N = 1'b1;

        // 141 = 100 + 25 + 10 + 5 + 1, immediate acks.
        exp_codes.push_back(3'd4);
        exp_codes.push_back(3'd3);
        exp_codes.push_back(3'd2);
        exp_codes.push_back(3'd1);
        exp_codes.push_back(3'd0);
        exp_done.push_back('{remain: 16'd0, fault: 1'b0});
        start_txn(16'd141, 1);
        check("c141_busy", bus.O_BUSY, 1'b1);
        check("c141_loaded", bus.O_REMAIN, 16'd141);
        check("c141_valid_early", bus.O_COIN_VALID, 1'b0);
        @(negedge I_CLK);
        check("c141_valid_latency", bus.O_COIN_VALID, 1'b1);
        finish_txn("c141");

        // Zero change: no coin, O_DONE two cycles after I_START.
        exp_done.push_back('{remain: 16'd0, fault: 1'b0});
        start_txn(16'd0, 1);
        check("c0_done_early", bus.O_DONE, 1'b0);
        @(negedge I_CLK);
        check("c0_done_latency", bus.O_DONE, 1'b1);
        @(negedge I_CLK);
        check("c0_done_pulse", bus.O_DONE, 1'b0);
        check("c0_idle", bus.O_BUSY, 1'b0);

        // 25 with a silent ejector: timeout fault, amount kept.
        exp_codes.push_back(3'd3);
        exp_done.push_back('{remain: 16'd25, fault: 1'b1});
        start_txn(16'd25, 0);
        finish_txn("c25_timeout");
        check("fault_sticky", bus.O_FAULT, 1'b1);
        check("fault_remain_kept", bus.O_REMAIN, 16'd25);

        // 1100 = 500 + 500 + 100 with acks three cycles late; fault cleared on start.
        exp_codes.push_back(3'd5);
        exp_codes.push_back(3'd5);
        exp_codes.push_back(3'd4);
        exp_done.push_back('{remain: 16'd0, fault: 1'b0});
        start_txn(16'd1100, 3);
        check("c1100_fault_cleared", bus.O_FAULT, 1'b0);
        finish_txn("c1100");

        // 600: reset right after the first coin is acknowledged.
        exp_codes.push_back(3'd5);
        start_txn(16'd600, 1);
        wait_valid("c600_first", 1'b1, 20);
        wait_valid("c600_ack", 1'b0, 20);
        check("c600_after_ack", bus.O_REMAIN, 16'd100);
        I_RESET_N = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge I_CLK);
        I_RESET_N = 1'b1;
        repeat (3) @(negedge I_CLK);
        check("midreset_no_done", bus.O_DONE, 1'b0);
        check("midreset_idle", bus.O_BUSY, 1'b0);

`ifdef COIN_INVENTORY_EN
        // One 100-coin, ten of the rest: 200 = 100 + 4 x 25.
        for (int i = 0; i < NUM_COINS; i++) begin
            refill(3'(i), (i == 4) ? CNT_W'(1) : CNT_W'(10));
        end
        for (int i = 0; i < 5; i++) exp_codes.push_back((i == 0) ? 3'd4 : 3'd3);
        exp_done.push_back('{remain: 16'd0, fault: 1'b0});
        start_txn(16'd200, 1);
        finish_txn("inv200");
        // 100-count is now 0, so 100 must be paid in quarters.
        for (int i = 0; i < 4; i++) exp_codes.push_back(3'd3);
        exp_done.push_back('{remain: 16'd0, fault: 1'b0});
        start_txn(16'd100, 1);
        finish_txn("inv100");
`endif

        repeat (2) @(negedge I_CLK);
        check("codes_drained", exp_codes.size(), 0);
        check("done_drained", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, max cycles O_COIN_VALID waits for I_COIN_ACK before faulting.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-denomination inventory counter.
REQ-003 SHALL have port I_CLK, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port I_RESET_N, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port I_START, input, 1, one-cycle request to dispense I_CHANGE.
REQ-006 SHALL have port I_CHANGE, input, 16, change amount in cents, sampled only with I_START.
REQ-007 SHALL have port I_COIN_ACK, input, 1, ejector confirms the presented coin was dispensed.
REQ-008 SHALL have port O_COIN_VALID, output, 1, coin request presented to ejector.
REQ-009 SHALL have port O_COIN_SEL, output, 3, coin code: 0=1, 1=5, 2=10, 3=25, 4=100, 5=500.
REQ-010 SHALL have port O_REMAIN, output, 16, amount still to dispense.
REQ-011 SHALL have port O_BUSY, output, 1, high in every state except S_IDLE.
REQ-012 SHALL have port O_DONE, output, 1, one-cycle pulse when the transaction completes.
REQ-013 SHALL have port O_FAULT, output, 1, sticky error flag, cleared by next accepted I_START.

Function
REQ-014 SHALL implement states S_IDLE, S_SELECT, S_EJECT, S_FINISH.
REQ-015 S_IDLE: I_START high SHALL load O_REMAIN<=I_CHANGE, clear O_FAULT, go to S_SELECT; I_START outside S_IDLE SHALL be ignored.
REQ-016 S_SELECT SHALL pick the largest available coin value <= O_REMAIN (greedy); found -> S_EJECT with O_COIN_VALID=1 and O_COIN_SEL set the next cycle; none or O_REMAIN==0 -> S_FINISH.
REQ-017 S_EJECT SHALL hold O_COIN_VALID and O_COIN_SEL stable until I_COIN_ACK is sampled high.
REQ-018 On an I_COIN_ACK sample, SHALL subtract the coin value from O_REMAIN, drop O_COIN_VALID, and return to S_SELECT; O_COIN_VALID SHALL be low at least one cycle between coins.
REQ-019 I_COIN_ACK while O_COIN_VALID is low SHALL be ignored.
REQ-020 A wait counter SHALL start at 0 on S_EJECT entry; if it reaches ACK_TIMEOUT with no ack, SHALL set O_FAULT, drop O_COIN_VALID, keep O_REMAIN, and go to S_FINISH.
REQ-021 S_FINISH SHALL pulse O_DONE for exactly one cycle and go to S_IDLE.
REQ-022 Latency: O_COIN_VALID SHALL rise 2 cycles after I_START is sampled; with I_CHANGE=0, O_DONE SHALL pulse 2 cycles after I_START.
REQ-023 Subtraction SHALL be 16-bit unsigned; greedy choice guarantees O_REMAIN never underflows.
REQ-024 O_REMAIN SHALL read 0 at O_DONE unless O_FAULT is set.

Reset
REQ-025 I_RESET_N low SHALL asynchronously force S_IDLE and set O_COIN_VALID=0, O_COIN_SEL=0, O_REMAIN=0, O_BUSY=0, O_DONE=0, O_FAULT=0, wait counter=0.
REQ-026 Reset mid-transaction SHALL abandon it with no O_DONE pulse.

Configuration
REQ-027 Macro COIN_INVENTORY_EN defined: SHALL add inputs I_REFILL (1), I_REFILL_SEL (3), I_REFILL_CNT (CNT_W), plus one CNT_W-bit count per denomination.
REQ-028 With COIN_INVENTORY_EN: I_REFILL in S_IDLE SHALL load the selected count; counts SHALL decrement on each ack; S_SELECT SHALL skip zero-count coins; no usable coin with O_REMAIN>0 SHALL set O_FAULT before S_FINISH.
REQ-029 With COIN_INVENTORY_EN, counts SHALL reset to 0.
REQ-030 Macro COIN_INVENTORY_EN undefined: SHALL treat all coins as unlimited and omit the refill ports.

Structure
REQ-031 A shared package SHALL hold state encodings, coin codes 0-5, and the coin-value table (1,5,10,25,100,500).
REQ-032 Sub-module coin_select SHALL be combinational: (remain, availability mask) -> (found, code, value).

Verification
REQ-033 I_START, I_CHANGE=141 -> codes 4,3,2,1,0 in order, immediate acks -> O_DONE, O_REMAIN=0.
REQ-034 I_CHANGE=0 -> no O_COIN_VALID; O_DONE 2 cycles after I_START.
REQ-035 I_CHANGE=1100, acks delayed 3 cycles -> codes 5,5,4; O_COIN_SEL stable during each wait.
REQ-036 I_CHANGE=25, ACK_TIMEOUT=4, no ack -> O_FAULT=1, O_REMAIN=25, O_DONE pulse.
REQ-037 I_CHANGE=600, reset asserted after first ack -> all outputs 0, S_IDLE, no O_DONE.
REQ-038 COIN_INVENTORY_EN, 100-count=1, others 10, I_CHANGE=200 -> codes 4,3,3,3,3; 100-count ends at 0.
